// File: rtl/upower_fetch_pc_unit.sv
// Program-counter and fetch sequencer for the uPower core: fetches over a req/ack
// port, holds the instruction for decode, and resolves b/bc/bclr/bcctr against LR/CTR.
module upower_fetch_pc_unit #(
    parameter int unsigned         PC_WIDTH  = 32,
    parameter int unsigned         XLEN      = 64,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
    parameter bit                  WORD_ADDR = 1'b1
) (
    input  logic                clock,
    input  logic                reset_n,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [31:0]         imem_rdata,
    output logic [31:0]         instr,
    output logic                instr_valid,
    input  logic                resolve_valid,
    input  logic [5:0]          opcode,
    input  logic [9:0]          xo,
    input  logic                aa,
    input  logic                lk,
    input  logic [4:0]          bo,
    input  logic                cond_true,
    input  logic [23:0]         li,
    input  logic [13:0]         bd,
    input  logic                spr_wr_en,
    input  logic                spr_sel,
    input  logic [XLEN-1:0]     spr_wdata,
    output logic [PC_WIDTH-1:0] pc,
    output logic [XLEN-1:0]     lr,
    output logic [XLEN-1:0]     ctr,
    output logic                branch_taken
);
    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_EXEC} state_t;

    localparam logic [PC_WIDTH-1:0] INC        = WORD_ADDR ? PC_WIDTH'(1) : PC_WIDTH'(4);
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = WORD_ADDR ? {PC_WIDTH{1'b1}} : ~PC_WIDTH'(3);

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [XLEN-1:0]     lr_q, lr_d;
    logic [XLEN-1:0]     ctr_q, ctr_d;
    logic [31:0]         instr_q, instr_d;
    logic                imem_req_q, imem_req_d;
    logic                instr_valid_q, instr_valid_d;
    logic                branch_taken_q, branch_taken_d;

    logic [PC_WIDTH-1:0] li_ext, bd_ext, disp_li, disp_bd;
    logic [PC_WIDTH-1:0] pc_inc, br_target;
    logic [XLEN-1:0]     ctr_n;
    logic                is_b, is_bc, is_bclr, is_bcctr, is_branch;
    logic                ctr_ok, cond_ok, br_taken;

    // Byte-addressed PCs scale displacements to instruction granularity.
    assign li_ext  = {{(PC_WIDTH-24){li[23]}}, li};
    assign bd_ext  = {{(PC_WIDTH-14){bd[13]}}, bd};
    assign disp_li = WORD_ADDR ? li_ext : {li_ext[PC_WIDTH-3:0], 2'b00};
    assign disp_bd = WORD_ADDR ? bd_ext : {bd_ext[PC_WIDTH-3:0], 2'b00};

    assign is_b      = (opcode == 6'd18);
    assign is_bc     = (opcode == 6'd16);
    assign is_bclr   = (opcode == 6'd19) && (xo == 10'd16);
    assign is_bcctr  = (opcode == 6'd19) && (xo == 10'd528);
    assign is_branch = is_b || is_bc || is_bclr || is_bcctr;

    assign pc_inc   = pc_q + INC;
    assign ctr_n    = ((is_bc || is_bclr) && !bo[2]) ? ctr_q - XLEN'(1) : ctr_q;
    assign ctr_ok   = is_bcctr || bo[2] || ((ctr_n != '0) ^ bo[1]);
    assign cond_ok  = bo[4] || (cond_true == bo[3]);
    assign br_taken = is_b || ((is_bc || is_bclr || is_bcctr) && ctr_ok && cond_ok);

    always_comb begin
        br_target = pc_inc;
        if (is_b) begin
            br_target = aa ? disp_li : pc_q + disp_li;
        end else if (is_bc) begin
            br_target = aa ? disp_bd : pc_q + disp_bd;
        end else if (is_bclr) begin
            br_target = lr_q[PC_WIDTH-1:0] & ALIGN_MASK;
        end else if (is_bcctr) begin
            br_target = ctr_q[PC_WIDTH-1:0] & ALIGN_MASK;
        end
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        lr_d           = lr_q;
        ctr_d          = ctr_q;
        instr_d        = instr_q;
        branch_taken_d = 1'b0;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (resolve_valid) begin
                    state_d = ST_FETCH;
                    if (is_branch) begin
                        // Target reads the old LR, so bclr+lk sees LR before relinking.
                        pc_d           = br_taken ? br_target : pc_inc;
                        branch_taken_d = br_taken;
                        if (is_bc || is_bclr) ctr_d = ctr_n;
                        if (lk) lr_d = XLEN'(pc_inc);
                    end else begin
                        pc_d = pc_inc;
                        if (spr_wr_en) begin
                            if (spr_sel) ctr_d = spr_wdata;
                            else         lr_d  = spr_wdata;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        imem_req_d    = (state_d == ST_FETCH);
        instr_valid_d = (state_d == ST_EXEC);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            pc_q           <= RESET_PC;
            lr_q           <= '0;
            ctr_q          <= '0;
            instr_q        <= '0;
            imem_req_q     <= 1'b0;
            instr_valid_q  <= 1'b0;
            branch_taken_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            lr_q           <= lr_d;
            ctr_q          <= ctr_d;
            instr_q        <= instr_d;
            imem_req_q     <= imem_req_d;
            instr_valid_q  <= instr_valid_d;
            branch_taken_q <= branch_taken_d;
        end
    end

    assign imem_req     = imem_req_q;
    assign imem_addr    = pc_q;
    assign instr        = instr_q;
    assign instr_valid  = instr_valid_q;
    assign pc           = pc_q;
    assign lr           = lr_q;
    assign ctr          = ctr_q;
    assign branch_taken = branch_taken_q;
endmodule

// File: tb/tb_upower_fetch_pc_unit.sv
// Bench for upower_fetch_pc_unit: a word-addressed (A) and a byte-addressed (B) instance
// share one directed stimulus stream and are checked each cycle against a behavioural model.
module tb_upower_fetch_pc_unit;
    logic        clock = 1'b0;
    logic        reset_n, imem_ack, resolve_valid, aa, lk, cond_true, spr_wr_en, spr_sel;
    logic [31:0] imem_rdata;
    logic [5:0]  opcode;
    logic [9:0]  xo;
    logic [4:0]  bo;
    logic [23:0] li;
    logic [13:0] bd;
    logic [63:0] spr_wdata;

    logic        a_req, a_iv, a_bt, b_req, b_iv, b_bt;
    logic [31:0] a_addr, a_instr, a_pc, b_addr, b_instr, b_pc;
    logic [63:0] a_lr, a_ctr, b_lr, b_ctr;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit cmp_en = 1'b1;

    // Behavioural model state, index 0 = instance A (word), 1 = instance B (byte).
    int          m_phase[2];   // 0 idle, 1 fetching, 2 holding instruction
    bit [31:0]   m_pc[2];
    bit [63:0]   m_lr[2], m_ctr[2];
    bit [31:0]   m_instr[2];
    bit          m_bt[2];
    bit [31:0]   m_rst_pc[2] = '{32'h0000_0000, 32'hFFFF_FFFC};

    always #5 clock = ~clock;

    upower_fetch_pc_unit #(.PC_WIDTH(32), .XLEN(64), .RESET_PC(32'h0000_0000), .WORD_ADDR(1'b1)) dut_a (
        .clock(clock), .reset_n(reset_n), .imem_req(a_req), .imem_addr(a_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr(a_instr), .instr_valid(a_iv), .resolve_valid(resolve_valid),
        .opcode(opcode), .xo(xo), .aa(aa), .lk(lk), .bo(bo), .cond_true(cond_true), .li(li), .bd(bd),
        .spr_wr_en(spr_wr_en), .spr_sel(spr_sel), .spr_wdata(spr_wdata), .pc(a_pc), .lr(a_lr),
        .ctr(a_ctr), .branch_taken(a_bt));

    upower_fetch_pc_unit #(.PC_WIDTH(32), .XLEN(64), .RESET_PC(32'hFFFF_FFFC), .WORD_ADDR(1'b0)) dut_b (
        .clock(clock), .reset_n(reset_n), .imem_req(b_req), .imem_addr(b_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr(b_instr), .instr_valid(b_iv), .resolve_valid(resolve_valid),
        .opcode(opcode), .xo(xo), .aa(aa), .lk(lk), .bo(bo), .cond_true(cond_true), .li(li), .bd(bd),
        .spr_wr_en(spr_wr_en), .spr_sel(spr_sel), .spr_wdata(spr_wdata), .pc(b_pc), .lr(b_lr),
        .ctr(b_ctr), .branch_taken(b_bt));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_exec(input int k);
        int        sc, dsp, kind;
        bit [31:0] ret, dest;
        bit [63:0] nctr;
        bit        ctr_good, cond_good, go;
        sc   = (k == 0) ? 1 : 4;
        ret  = m_pc[k] + 32'(sc);
        kind = (opcode == 18) ? 1 : (opcode == 16) ? 2 :
               (opcode == 19 && xo == 16) ? 3 : (opcode == 19 && xo == 528) ? 4 : 0;
        if (kind == 0) begin
            m_pc[k] = ret;
            if (spr_wr_en && spr_sel)  m_ctr[k] = spr_wdata;
            if (spr_wr_en && !spr_sel) m_lr[k]  = spr_wdata;
            return;
        end
        if (kind == 1) dsp = li[23] ? int'(li) - (1 << 24) : int'(li);
        else           dsp = bd[13] ? int'(bd) - (1 << 14) : int'(bd);
        nctr = m_ctr[k];
        if ((kind == 2 || kind == 3) && !bo[2]) nctr = m_ctr[k] - 64'd1;
        ctr_good  = (kind == 4) || bo[2] || ((nctr != 0) != bo[1]);
        cond_good = bo[4] || (cond_true == bo[3]);
        go        = (kind == 1) || (ctr_good && cond_good);
        if (kind <= 2)      dest = aa ? 32'(dsp * sc) : m_pc[k] + 32'(dsp * sc);
        else if (kind == 3) dest = (m_lr[k][31:0] / 32'(sc)) * 32'(sc);
        else                dest = (m_ctr[k][31:0] / 32'(sc)) * 32'(sc);
        m_pc[k]  = go ? dest : ret;
        m_ctr[k] = nctr;
        if (lk) m_lr[k] = {32'h0, ret};
        m_bt[k]  = go;
    endtask

    task automatic model_step(input int k);
        if (!reset_n) begin
            m_phase[k] = 0; m_pc[k] = m_rst_pc[k]; m_lr[k] = 0; m_ctr[k] = 0;
            m_instr[k] = 0; m_bt[k] = 0;
            return;
        end
        m_bt[k] = 0;
        case (m_phase[k])
            0: m_phase[k] = 1;
            1: if (imem_ack) begin m_instr[k] = imem_rdata; m_phase[k] = 2; end
            default: if (resolve_valid) begin model_exec(k); m_phase[k] = 1; end
        endcase
    endtask

    always begin
        @(posedge clock);
        cyc++;
        model_step(0);
        model_step(1);
        #1;
        if (cmp_en) begin
            chk("A pc", a_pc, m_pc[0]);            chk("B pc", b_pc, m_pc[1]);
            chk("A imem_addr", a_addr, m_pc[0]);   chk("B imem_addr", b_addr, m_pc[1]);
            chk("A imem_req", a_req, m_phase[0] == 1);  chk("B imem_req", b_req, m_phase[1] == 1);
            chk("A instr_valid", a_iv, m_phase[0] == 2); chk("B instr_valid", b_iv, m_phase[1] == 2);
            chk("A instr", a_instr, m_instr[0]);   chk("B instr", b_instr, m_instr[1]);
            chk("A lr", a_lr, m_lr[0]);            chk("B lr", b_lr, m_lr[1]);
            chk("A ctr", a_ctr, m_ctr[0]);         chk("B ctr", b_ctr, m_ctr[1]);
            chk("A branch_taken", a_bt, m_bt[0]);  chk("B branch_taken", b_bt, m_bt[1]);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic set_op(input logic [5:0] o, input logic [9:0] x, input logic a, input logic l,
                          input logic [4:0] b, input logic c, input logic [23:0] lv, input logic [13:0] bv);
        opcode = o; xo = x; aa = a; lk = l; bo = b; cond_true = c; li = lv; bd = bv;
    endtask

    // Entered at a negedge with the DUT fetching; leaves at a negedge with the DUT fetching again.
    task automatic run_instr(input int delay, input int stall, input logic [31:0] rdata);
        imem_rdata = rdata;
        repeat (delay) begin imem_ack = 1'b0; @(negedge clock); end
        imem_ack = 1'b1;
        @(negedge clock);
        imem_ack = 1'b0;
        repeat (stall) @(negedge clock);
        resolve_valid = 1'b1;
        @(negedge clock);
        resolve_valid = 1'b0;
    endtask

    task automatic mtspr(input logic sel, input logic [63:0] data);
        set_op(6'd31, 10'd0, 1'b0, 1'b0, 5'd0, 1'b0, 24'd0, 14'd0);
        spr_wr_en = 1'b1; spr_sel = sel; spr_wdata = data;
        run_instr(0, 0, 32'h7C00_03A6);
        spr_wr_en = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; resolve_valid = 1'b0;
        spr_wr_en = 1'b0; spr_sel = 1'b0; spr_wdata = 64'h0;
        set_op(6'd31, 10'd0, 1'b0, 1'b0, 5'd0, 1'b0, 24'd0, 14'd0);

        // 1: reset and straight-line fetch.
        repeat (2) @(negedge clock);
        chk("reset imem_req", a_req, 1'b0);
        chk("reset pc A", a_pc, 32'h0);
        chk("reset pc B", b_pc, 32'hFFFF_FFFC);
        reset_n = 1'b1;
        @(negedge clock);
        chk("first req after release", a_req, 1'b1);
        chk("seq addr0", a_addr, 32'd0);
        for (int i = 1; i <= 3; i++) begin
            run_instr(0, 0, 32'h7C00_0000 + 32'(i));
            chk("seq addr", a_addr, 32'(i));
        end
        chk("byte wrap pc B", b_pc, 32'h8);

        // 2: wait states and EXEC stall.
        imem_rdata = 32'h4800_0010;
        for (int i = 0; i < 3; i++) begin
            chk("wait req held", a_req, 1'b1);
            chk("wait no valid", a_iv, 1'b0);
            @(negedge clock);
        end
        chk("wait req 4th", a_req, 1'b1);
        imem_ack = 1'b1;
        @(negedge clock);
        imem_ack = 1'b0;
        chk("wait instr", a_instr, 32'h4800_0010);
        chk("wait valid", a_iv, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("stall pc", a_pc, 32'd3);
            @(negedge clock);
        end
        resolve_valid = 1'b1;
        @(negedge clock);
        resolve_valid = 1'b0;
        chk("after stall pc", a_pc, 32'd4);
        repeat (4) run_instr(0, 0, 32'h6000_0000);
        chk("pc before b", a_pc, 32'd8);

        // 3: b relative with link, then absolute.
        set_op(6'd18, 10'd0, 1'b0, 1'b1, 5'd0, 1'b0, 24'hFFFFFC, 14'd0);
        run_instr(0, 0, 32'h4BFF_FFFD);
        chk("b rel pc", a_pc, 32'd4);
        chk("b rel lr", a_lr, 64'd9);
        chk("b rel taken", a_bt, 1'b1);
        chk("b rel pc B", b_pc, 32'hC);
        imem_ack = 1'b0;
        @(negedge clock);
        chk("b taken pulse ends", a_bt, 1'b0);
        set_op(6'd18, 10'd0, 1'b1, 1'b0, 5'd0, 1'b0, 24'h000020, 14'd0);
        run_instr(1, 0, 32'h4800_0082);
        chk("b abs pc", a_pc, 32'h20);
        chk("b abs pc B", b_pc, 32'h80);

        // 4: bc counted loop.
        mtspr(1'b1, 64'd3);
        set_op(6'd16, 10'd0, 1'b0, 1'b0, 5'b10000, 1'b0, 24'd0, 14'h3FFE);
        run_instr(0, 0, 32'h4200_FFF8);
        chk("bc1 ctr", a_ctr, 64'd2);  chk("bc1 pc", a_pc, 32'h1F);
        run_instr(0, 0, 32'h4200_FFF8);
        chk("bc2 ctr", a_ctr, 64'd1);  chk("bc2 pc", a_pc, 32'h1D);
        run_instr(0, 0, 32'h4200_FFF8);
        chk("bc3 ctr", a_ctr, 64'd0);  chk("bc3 pc", a_pc, 32'h1E);
        chk("bc3 not taken", a_bt, 1'b0);

        // 5: bclr with link, bcctr not taken / taken with ignored mtspr.
        mtspr(1'b0, 64'h40);
        set_op(6'd18, 10'd0, 1'b1, 1'b0, 5'd0, 1'b0, 24'h000010, 14'd0);
        run_instr(0, 0, 32'h4800_0042);
        chk("pc before bclr", a_pc, 32'h10);
        set_op(6'd19, 10'd16, 1'b0, 1'b1, 5'b10100, 1'b0, 24'd0, 14'd0);
        run_instr(0, 0, 32'h4E80_0021);
        chk("bclr pc", a_pc, 32'h40);
        chk("bclr lr", a_lr, 64'h11);
        chk("bclr lr B", b_lr, 64'h44);
        mtspr(1'b1, 64'h80);
        set_op(6'd19, 10'd528, 1'b0, 1'b0, 5'b01100, 1'b0, 24'd0, 14'd0);
        run_instr(0, 0, 32'h4D80_0420);
        chk("bcctr nt pc", a_pc, 32'h42);
        chk("bcctr nt ctr", a_ctr, 64'h80);
        mtspr(1'b1, 64'h83);
        set_op(6'd19, 10'd528, 1'b0, 1'b0, 5'b10100, 1'b0, 24'd0, 14'd0);
        spr_wr_en = 1'b1; spr_sel = 1'b1; spr_wdata = 64'hDEAD;
        run_instr(0, 0, 32'h4E80_0420);
        spr_wr_en = 1'b0;
        chk("bcctr pc", a_pc, 32'h83);
        chk("bcctr pc B aligned", b_pc, 32'h80);
        chk("bcctr mtspr ignored", a_ctr, 64'h83);

        // CTR decrement wraps from zero.
        mtspr(1'b1, 64'd0);
        set_op(6'd16, 10'd0, 1'b0, 1'b0, 5'b00000, 1'b0, 24'd0, 14'd5);
        run_instr(2, 1, 32'h4000_0014);
        chk("ctr wrap", a_ctr, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("ctr wrap pc", a_pc, 32'h89);

        // 6: byte-mode bd=1 step, then reset during FETCH and during EXEC.
        set_op(6'd16, 10'd0, 1'b0, 1'b0, 5'b10100, 1'b0, 24'd0, 14'd1);
        run_instr(0, 0, 32'h4280_0004);
        chk("bd1 pc A", a_pc, 32'h8A);
        chk("bd1 pc B", b_pc, 32'h9C);
        set_op(6'd31, 10'd0, 1'b0, 1'b0, 5'd0, 1'b0, 24'd0, 14'd0);
        imem_ack = 1'b0;
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        chk("rst fetch req", a_req, 1'b0);
        chk("rst fetch pc A", a_pc, 32'h0);
        chk("rst fetch pc B", b_pc, 32'hFFFF_FFFC);
        chk("rst fetch ctr", a_ctr, 64'h0);
        reset_n = 1'b1;
        @(negedge clock);
        imem_ack = 1'b1; imem_rdata = 32'h3860_0001;
        @(negedge clock);
        imem_ack = 1'b0;
        chk("exec before rst", a_iv, 1'b1);
        reset_n = 1'b0;
        @(negedge clock);
        chk("rst exec valid", a_iv, 1'b0);
        chk("rst exec instr", a_instr, 32'h0);
        reset_n = 1'b1;
        @(negedge clock);
        run_instr(0, 0, 32'h6000_0000);
        chk("post reset pc B", b_pc, 32'h0);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/upower_fetch_pc_unit.md
Name: upower_fetch_pc_unit

Overview:
- Parametrised program-counter and fetch-sequencing unit for the uPower core.
- Issues instruction-memory requests with a req/ack handshake and latches the returned instruction.
- Resolves all branch forms (b, bc, bclr, bcctr) with AA/LK/BO semantics, and owns the LR and CTR special registers.
- Decode/ALU supplies resolve information once per instruction.

Parameters:
- PC_WIDTH, 32, width of PC and imem_addr.
- XLEN, 64, width of LR, CTR and spr_wdata.
- RESET_PC, 0, PC value loaded at reset.
- WORD_ADDR, 1. 1: PC counts instructions, increment 1, displacements used unscaled. 0: byte PC, increment 4, displacements shifted left 2, targets from LR/CTR have bits [1:0] forced to 0.

Ports:
- clock  in  1  system clock, all state updates on posedge.
- reset_n  in  1  synchronous active-low reset, sampled on posedge clock.
- imem_req  out  1  fetch request, held until imem_ack.
- imem_addr  out  PC_WIDTH  fetch address, always equal to pc.
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle.
- imem_rdata  in  32  instruction word.
- instr  out  32  latched instruction.
- instr_valid  out  1  instr held for decode; high in EXEC.
- resolve_valid  in  1  decode/ALU finished current instruction.
- opcode  in  6  primary opcode of current instruction.
- xo  in  10  extended opcode (opcode 19 forms).
- aa  in  1  absolute-address bit.
- lk  in  1  link bit.
- bo  in  5  BO field.
- cond_true  in  1  CR bit selected by BI, computed externally.
- li  in  24  I-form displacement.
- bd  in  14  B-form displacement.
- spr_wr_en  in  1  mtspr request.
- spr_sel  in  1  0 = LR, 1 = CTR.
- spr_wdata  in  XLEN  mtspr data.
- pc  out  PC_WIDTH  current PC.
- lr  out  XLEN  link register.
- ctr  out  XLEN  count register.
- branch_taken  out  1  one-cycle pulse after a taken branch resolves.

Behaviour:
- Reset values (reset_n=0 at posedge): pc=RESET_PC, lr=0, ctr=0, instr=0, imem_req=0, instr_valid=0, branch_taken=0, state=IDLE.
- Reset mid-fetch or mid-EXEC abandons the operation; imem_req is low the cycle after reset is sampled.
- State IDLE: exits to FETCH on the first posedge with reset_n=1.
- State FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ack: instr<=imem_rdata, next state EXEC.
  - Zero-wait ack (same cycle as req) is legal.
- State EXEC:
  - instr_valid=1; waits indefinitely for resolve_valid.
  - On resolve_valid: pc, lr and ctr update at the same edge; next state FETCH.
  - Minimum 2 cycles per instruction.
- INC = WORD_ADDR ? 1 : 4.
- Displacements: D(x) = sign-extend x to PC_WIDTH, shifted left 2 when WORD_ADDR=0.
- All PC arithmetic is modulo 2^PC_WIDTH; wrap-around is silent.
- opcode 18 (b): always taken. target = aa ? D(li) : pc + D(li).
- opcode 16 (bc):
  - If bo[2]=0: ctr_n = ctr-1 (wraps 0 -> all-ones); else ctr_n = ctr.
  - ctr_ok = bo[2] | ((ctr_n!=0) ^ bo[1]).
  - cond_ok = bo[4] | (cond_true == bo[3]).
  - taken = ctr_ok & cond_ok.
  - target = aa ? D(bd) : pc + D(bd).
- opcode 19, xo=16 (bclr): CTR and condition logic as bc. target = old lr[PC_WIDTH-1:0].
- opcode 19, xo=528 (bcctr):
  - No CTR decrement; bo[2] is treated as 1.
  - taken = cond_ok.
  - target = old ctr[PC_WIDTH-1:0].
- Next PC: taken ? target : pc + INC.
- ctr <= ctr_n for bc and bclr, whether or not the branch is taken.
- LK=1 on any branch form: lr <= zero-extend(pc + INC), taken or not.
  - bclr with lk=1 uses the old lr as target, then overwrites lr.
- Non-branch opcodes: pc <= pc + INC.
- spr_wr_en is honoured only with resolve_valid in EXEC and a non-branch opcode; it writes lr or ctr per spr_sel.
  - spr_wr_en on a branch instruction is ignored; branch updates win.
- branch_taken is registered: high the cycle after resolve of a taken branch, for one cycle.
- Inputs other than reset_n and imem_ack are ignored outside EXEC.

Test Plan:
1. Reset/sequential: reset_n low for 2 cycles, then high, imem_ack tied 1, non-branch opcode 31, resolve each EXEC -> imem_addr sequence 0,1,2,3; first imem_req exactly 1 cycle after reset release; branch_taken never high.
2. Wait states: ack delayed 3 cycles with rdata=0x48000010 -> imem_req held 4 cycles, instr=0x48000010 latched, instr_valid only after ack; stall 5 cycles in EXEC holds pc.
3. b relative and absolute: pc=8. opcode 18, li=0xFFFFFC (-4), aa=0, lk=1 -> pc=4, lr=9, branch_taken pulses. Then aa=1, li=0x000020 -> pc=0x20.
4. bc loop: ctr=3 via mtspr, then bc with bo=5'b10000, bd=-2 resolved repeatedly -> taken twice (ctr 2, 1), third not taken (ctr 0), pc = branch pc+1.
5. bclr/bcctr: lr=0x40, bclr bo=5'b10100 lk=1 at pc=0x10 -> pc=0x40, lr=0x11. ctr=0x80, bcctr with cond_true=0 and bo=5'b01100 -> not taken, ctr stays 0x80.
6. WORD_ADDR=0 with reset mid-fetch: pc=0xFFFFFFFC, non-branch -> pc wraps to 0. bd=1 relative -> +4. reset_n low during FETCH -> imem_req low next cycle, pc=RESET_PC.
